// File: rtl/ar_responder_pkg.sv
// Shared types for the AXI read responder and the traffic generator that drives it.
// Holds the AR/R channel structs, the queued-request entry, and the beat address helper.
package ar_responder_pkg;

  localparam int ADDR_W   = 32;
  localparam int ID_W     = 4;
  localparam int LEN_W    = 8;
  localparam int R_DATA_W = 64;

  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY = 2'b00;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } ax_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]     id;
    logic [R_DATA_W-1:0] data;
    resp_t               resp;
    logic                last;
  } r_chan_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [ID_W-1:0]   id;
  } ar_entry_t;

  typedef ar_entry_t r_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_BURST
  } state_e;

  // Address of a given beat; the add wraps naturally at the address width.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [LEN_W-1:0]  beat,
                                                  input int unsigned       stride);
    return base + ADDR_W'(beat) * ADDR_W'(stride);
  endfunction

endpackage

// File: rtl/ar_responder_ar_queue.sv
// DEPTH-entry FIFO of accepted AR requests.
// Pointers wrap on log2(DEPTH) bits; a separate occupancy counter gives full/empty.
module ar_queue
  import ar_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  ar_entry_t entry_i,
  input  logic      pop_i,
  output ar_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  ar_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only ever read after being written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/ar_responder.sv
// Subordinate-side AXI read responder: queues AR requests and returns R bursts whose
// data is the beat address, after a programmable delay sampled at request pop.
//
// state    | meaning
// ST_IDLE  | waiting for a queued request; pops head when one is present
// ST_DELAY | counting down response delay before the first beat
// ST_BURST | presenting beats until the last one is accepted
module ar_responder
  import ar_responder_pkg::*;
#(
  parameter type ax_channel_t = ax_chan_t,
  parameter type r_channel_t  = r_chan_t,
  parameter int  DEPTH        = 4,
  parameter int  DATA_W       = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ar_valid_i,
  input  ax_channel_t ar_data_i,
  output logic        ar_ready_o,
  output logic        r_valid_o,
  output r_channel_t  r_data_o,
  input  logic        r_ready_i,
  input  logic        enable_i,
  input  logic [7:0]  resp_delay_i,
  output logic        busy_o,
  output logic [15:0] served_o
);

  localparam int unsigned STRIDE = DATA_W / 8;

  state_e      state_q, state_d;
  ar_entry_t   push_entry;
  ar_entry_t   head;
  ar_entry_t   cur_q;
  logic [7:0]  delay_q;
  logic [7:0]  beat_q;
  logic [15:0] served_q;
  logic        full;
  logic        empty;
  logic        pop;
  logic        is_last;
  logic        r_hs;
  logic [DATA_W-1:0] beat_data;

  assign push_entry.addr = ar_data_i.addr;
  assign push_entry.len  = ar_data_i.len;
  assign push_entry.id   = ar_data_i.id;

  assign ar_ready_o = enable_i && !full;

  ar_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (ar_valid_i && ar_ready_o),
    .entry_i(push_entry),
    .pop_i  (pop),
    .head_o (head),
    .full_o (full),
    .empty_o(empty)
  );

  assign is_last = (beat_q == cur_q.len);
  assign r_hs    = (state_q == ST_BURST) && r_ready_i;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          // A zero delay skips the countdown so the first beat follows the pop cycle.
          state_d = (resp_delay_i == 8'd0) ? ST_BURST : ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (delay_q == 8'd0) state_d = ST_BURST;
      end
      ST_BURST: begin
        if (r_ready_i && is_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      delay_q  <= '0;
      beat_q   <= '0;
      served_q <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        cur_q   <= head;
        delay_q <= resp_delay_i - 8'd1;
        beat_q  <= '0;
      end else if (state_q == ST_DELAY && delay_q != 8'd0) begin
        delay_q <= delay_q - 8'd1;
      end
      if (r_hs) begin
        beat_q <= beat_q + 8'd1;
        if (is_last) served_q <= served_q + 16'd1;
      end
    end
  end

  assign beat_data = DATA_W'(beat_addr(cur_q.addr, beat_q, STRIDE));

  always_comb begin
    r_data_o  = '0;
    r_valid_o = (state_q == ST_BURST);
    if (r_valid_o) begin
      r_data_o.data = beat_data;
      r_data_o.id   = cur_q.id;
      r_data_o.resp = RESP_OKAY;
      r_data_o.last = is_last;
    end
  end

  assign busy_o   = !empty || (state_q != ST_IDLE);
  assign served_o = served_q;

endmodule

// File: tb/tb_ar_responder.sv
// Bench for ar_responder: directed timing scenarios plus randomized traffic checked
// against a beat-list model built from accepted AR requests.
module tb_ar_responder;
  import ar_responder_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ar_valid = 1'b0;
  ax_chan_t    ar_data = '0;
  logic        ar_ready;
  logic        r_valid;
  r_chan_t     r_data;
  logic        r_ready = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  resp_delay = 8'd0;
  logic        busy;
  logic [15:0] served;

  int n_checks = 0;
  int n_errors = 0;
  int rdy_mode = 1;
  int exp_served = 0;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  id;
    logic        last;
  } exp_beat_t;

  exp_beat_t exp_q[$];
  logic      stall_prev = 1'b0;
  r_chan_t   data_prev;

  always #5 clk_i = ~clk_i;

  ar_responder dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .ar_valid_i  (ar_valid),
    .ar_data_i   (ar_data),
    .ar_ready_o  (ar_ready),
    .r_valid_o   (r_valid),
    .r_data_o    (r_data),
    .r_ready_i   (r_ready),
    .enable_i    (enable),
    .resp_delay_i(resp_delay),
    .busy_o      (busy),
    .served_o    (served)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk_i) begin
    #1;
    case (rdy_mode)
      0:       r_ready = 1'b0;
      1:       r_ready = 1'b1;
      default: r_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Model: each accepted AR expands into its list of beats; R handshakes consume them in order.
  always @(negedge clk_i) begin
    exp_beat_t e;
    if (!rst_ni) begin
      exp_q.delete();
      exp_served = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("r_hold_valid", 64'(r_valid), 64'd1);
        chk("r_hold_data", r_data.data, data_prev.data);
        chk("r_hold_ctl", 64'({r_data.id, r_data.resp, r_data.last}),
            64'({data_prev.id, data_prev.resp, data_prev.last}));
      end
      if (r_valid && r_ready) begin
        chk("r_expected_avail", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("r_data", r_data.data, e.data);
          chk("r_id_resp_last", 64'({r_data.id, r_data.resp, r_data.last}),
              64'({e.id, RESP_OKAY, e.last}));
          if (e.last) exp_served++;
        end
      end
      if (ar_valid && ar_ready) begin
        for (int i = 0; i <= int'(ar_data.len); i++) begin
          logic [31:0] a;
          a = ar_data.addr + 32'(i * 8);
          e.data = {32'h0, a};
          e.id   = ar_data.id;
          e.last = (i == int'(ar_data.len));
          exp_q.push_back(e);
        end
      end
      stall_prev = r_valid && !r_ready;
      data_prev  = r_data;
    end
  end

  // Leaves ar_valid high after the handshake negedge; the caller must follow promptly.
  task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
    int n = 0;
    @(posedge clk_i);
    #1;
    ar_valid     = 1'b1;
    ar_data.addr = a;
    ar_data.len  = l;
    ar_data.id   = id;
    @(negedge clk_i);
    while (!ar_ready && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 3000) chk("ar_accept_timeout", 64'(ar_ready), 64'd1);
  endtask

  task automatic measure_latency(input string tag, input int exp_lat);
    int n = 0;
    @(posedge clk_i);
    #1 ar_valid = 1'b0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!r_valid && n < 300);
    chk(tag, 64'(n), 64'(exp_lat));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    @(posedge clk_i);
    #1 ar_valid = 1'b0;
    do begin
      @(negedge clk_i);
      n++;
    end while (busy && n < budget);
    chk({tag, "_drained"}, 64'(busy), 64'd0);
    chk({tag, "_model_empty"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_served_model"}, 64'(served), 64'(exp_served[15:0]));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(posedge clk_i);
    #2;
    chk("rst_ar_ready", 64'(ar_ready), 64'd0);
    chk("rst_r_valid", 64'(r_valid), 64'd0);
    chk("rst_r_data", r_data.data, 64'd0);
    chk("rst_r_ctl", 64'({r_data.id, r_data.resp, r_data.last}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_served", 64'(served), 64'd0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1 enable = 1'b1;

    // single 4-beat burst, zero delay
    rdy_mode   = 1;
    resp_delay = 8'd0;
    send_ar(32'h1000, 8'd3, 4'd5);
    measure_latency("t1_latency", 2);
    chk("t1_beat0", r_data.data, 64'h1000);
    wait_idle("t1", 200);
    chk("t1_served", 64'(served), 64'd1);

    // delay of 10 on a single-beat burst
    resp_delay = 8'd10;
    send_ar(32'h0abc_0000, 8'd0, 4'd2);
    measure_latency("t2_latency", 12);
    chk("t2_last", 64'(r_data.last), 64'd1);
    wait_idle("t2", 200);
    chk("t2_served", 64'(served), 64'd2);

    // queue fills while R is stalled
    rdy_mode   = 0;
    resp_delay = 8'd1;
    for (int i = 0; i < 5; i++) send_ar(32'h2000 + 32'(i) * 32'h100, 8'(i), 4'(i));
    @(posedge clk_i);
    #1;
    ar_data.addr = 32'h2500;
    ar_data.len  = 8'd5;
    ar_data.id   = 4'd5;
    @(negedge clk_i);
    chk("t4_ready_after_5", 64'(ar_ready), 64'd0);
    repeat (3) @(negedge clk_i);
    chk("t4_ready_held_low", 64'(ar_ready), 64'd0);
    chk("t4_busy", 64'(busy), 64'd1);
    rdy_mode = 1;
    send_ar(32'h2500, 8'd5, 4'd5);
    wait_idle("t4", 2000);
    chk("t4_served", 64'(served), 64'd8);

    // disable after two queued requests
    rdy_mode   = 0;
    resp_delay = 8'd2;
    send_ar(32'h3000, 8'd2, 4'd7);
    send_ar(32'h3100, 8'd1, 4'd8);
    @(posedge clk_i);
    #1;
    enable       = 1'b0;
    ar_data.addr = 32'h3200;
    #1 chk("t6_ready_off", 64'(ar_ready), 64'd0);
    repeat (8) @(negedge clk_i);
    rdy_mode = 1;
    repeat (4) @(negedge clk_i);
    wait_idle("t6", 500);
    chk("t6_served", 64'(served), 64'd10);
    enable = 1'b1;

    // randomized traffic with random R backpressure
    rdy_mode   = 2;
    resp_delay = 8'd0;
    send_ar(32'hFFFF_FFF0, 8'd3, 4'd9);
    for (int i = 0; i < 20; i++) begin
      resp_delay = 8'($urandom_range(0, 4));
      send_ar($urandom, 8'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_i);
        #1 ar_valid = 1'b0;
        repeat ($urandom_range(1, 5)) @(posedge clk_i);
      end
    end
    wait_idle("rand", 10000);
    chk("rand_served", 64'(served), 64'd31);

    // reset in the middle of a burst
    rdy_mode   = 1;
    resp_delay = 8'd0;
    send_ar(32'h4000, 8'd7, 4'd3);
    @(posedge clk_i);
    #1 ar_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!r_valid && n < 100);
    chk("t7_beat0", r_data.data, 64'h4000);
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("t7_rst_r_valid", 64'(r_valid), 64'd0);
    chk("t7_rst_served", 64'(served), 64'd0);
    chk("t7_rst_busy", 64'(busy), 64'd0);
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    send_ar(32'h5000, 8'd0, 4'd1);
    wait_idle("t7", 200);
    chk("t7_served_after", 64'(served), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
